adc_uart_streamer: RTL and testbench
====================================

Name: adc_uart_streamer

Overview:
Parametrised successor to the fixed-message UART sequencer beside the SAR ADC. It accepts tagged ADC samples from up to NUM_CH converters and buffers them in a small FIFO. Each sample is sent as an ASCII hex line through the existing UART_TX start/done handshake. It sits between the ADC(s) and UART_TX, clocked from CLOCK_50.

Parameters:
DATA_W, 8, sample width in bits (1..16); NHEX = ceil(DATA_W/4) hex digits per sample
NUM_CH, 1, number of sample channels (1..8); CH_W = max(1, clog2(NUM_CH))
FIFO_DEPTH, 4, sample FIFO entries (power of 2, >= 2)

Ports:
CLOCK_50  in  1  single system clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
sample_valid  in  1  one-cycle strobe; sample_ch/sample_data valid this cycle
sample_ch  in  CH_W  channel tag of the sample
sample_data  in  DATA_W  ADC result
ovr_clr  in  1  clears the sticky overrun flag
uart_done  in  1  UART_TX idle level (from the UART clock domain)
uart_start  out  1  character request to UART_TX
uart_data  out  8  character byte to UART_TX
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
overrun  out  1  sticky: a sample was dropped
busy  out  1  FSM not in IDLE, or FIFO non-empty

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-low on reset_n.
- Reset values: uart_start=0, uart_data=8'h00, fifo_full=0, overrun=0, busy=0. FIFO pointers and count = 0. FSM = IDLE. Character index = 0. uart_done synchroniser flops = 1.
- uart_done passes through a 2-flop synchroniser (done_s) before use.
- FIFO write:
  - A sample is accepted when sample_valid=1 and (count < FIFO_DEPTH or a pop occurs in the same cycle).
  - Otherwise it is dropped and overrun is set.
  - overrun stays set until ovr_clr=1 or reset. If set and clear happen in the same cycle, set wins.
- FIFO pop: only in IDLE when count > 0. The head entry {ch, data} is latched into a frame register.
- Frame format, characters in order:
  - If NUM_CH > 1: '0'+ch (0x30..0x37), then ':' (0x3A).
  - NHEX hex digits, MSB nibble first, upper case: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46. The top nibble is zero-padded when DATA_W is not a multiple of 4.
  - Terminator LF (0x0A), then CR (0x0D).
  - Frame length L = NHEX + 2 + (NUM_CH > 1 ? 2 : 0).
- FSM states:
  - IDLE: if count > 0, pop and go to LOAD.
  - LOAD: uart_data <= character[idx]. Go to REQ when done_s=1, otherwise stay.
  - REQ: uart_start=1, uart_data held. Stay until done_s=0 (level handshake, tolerates the slower UART clock), then uart_start=0 and go to WAIT.
  - WAIT: when done_s=1, if idx = L-1 then idx=0 and go to IDLE, else idx+1 and go to LOAD.
- uart_data is stable from LOAD entry until the next LOAD. uart_start never asserts outside REQ.
- Latency: a sample accepted at edge k into an empty FIFO, with the FSM idle and done_s=1, gives uart_start=1 after edge k+3 (pop at k+1, LOAD at k+2, REQ at k+3).
- Frames never interleave. Samples arriving mid-frame queue in the FIFO.
- fifo_full = (count == FIFO_DEPTH). busy = (state != IDLE) | (count != 0).
- reset_n=0 mid-frame: the frame is abandoned, the FIFO is emptied and uart_start drops on the next edge. The UART may finish its current byte on its own.

Test Plan:
1. DATA_W=8, NUM_CH=1: sample 0x3C, uart_done model busy 10 cycles per char -> bytes 0x33, 0x43, 0x0A, 0x0D, then busy=0.
2. DATA_W=10, NUM_CH=4: ch=2, data=0x2A5 -> 0x32, 0x3A, 0x32, 0x41, 0x35, 0x0A, 0x0D. Also data=0x00F -> digits 0x30, 0x30, 0x46.
3. FIFO_DEPTH=4, uart_done held 0: push 6 samples 0x01..0x06 -> first popped into frame register, FIFO holds 0x02..0x05 with fifo_full=1, 0x06 dropped, overrun=1. Release uart_done -> frames for 0x01..0x05 in order. Pulse ovr_clr -> overrun=0.
4. Handshake: uart_done stays 1 for 5 cycles after uart_start rises -> uart_start held high until done_s falls, then one cycle low. No duplicate character is sent.
5. FIFO full, sample_valid coincident with pop -> sample accepted, overrun stays 0, count stays FIFO_DEPTH.
6. reset_n=0 while the 2nd character of a frame is in REQ -> next edge: uart_start=0, uart_data=0x00, fifo_full=0, busy=0. After release, a new sample starts a clean frame at character 0.

Source files
------------

// File: rtl/adc_uart_streamer.sv
// Buffers tagged ADC samples in a small FIFO and streams each one to UART_TX
// as an upper-case ASCII hex line ("c:HHH\n\r") over the start/done level handshake.
module adc_uart_streamer #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              ovr_clr,
  input  logic              uart_done,
  output logic              uart_start,
  output logic [7:0]        uart_data,
  output logic              fifo_full,
  output logic              overrun,
  output logic              busy
);

  localparam int NHEX      = (DATA_W + 3) / 4;
  localparam int HDR       = (NUM_CH > 1) ? 2 : 0;
  localparam int FRAME_LEN = NHEX + 2 + HDR;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENT_W     = CH_W + DATA_W;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LF    = IDX_W'(FRAME_LEN - 2);
  localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(HDR + NHEX - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT} state_t;

  logic               done_meta_reg, done_s_reg;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               overrun_reg;
  logic               push, pop;
  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CH_W-1:0]    frame_ch_reg;
  logic [DATA_W-1:0]  frame_data_reg;
  logic               uart_start_reg;
  logic [7:0]         uart_data_reg;
  logic [NHEX*4-1:0]  data_pad;
  logic [NHEX*8-1:0]  hex_line;
  logic [IDX_W-1:0]   nib_sel;
  logic [7:0]         cur_char;

  // uart_done comes from the slower UART clock domain.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      done_meta_reg <= 1'b1;
      done_s_reg    <= 1'b1;
    end else begin
      done_meta_reg <= uart_done;
      done_s_reg    <= done_meta_reg;
    end
  end

  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign pop  = (state_reg == IDLE) && (count_reg != '0);
  assign push = sample_valid && ((count_reg != CNT_FULL) || pop);

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr_reg] <= {sample_ch, sample_data};
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (sample_valid && !push) overrun_reg <= 1'b1;
      else if (ovr_clr)          overrun_reg <= 1'b0;
    end
  end

  always_comb begin
    data_pad               = '0;
    data_pad[DATA_W-1:0]   = frame_data_reg;
  end

  // Nibble gi (0 = least significant) as an upper-case ASCII hex digit.
  for (genvar gi = 0; gi < NHEX; gi++) begin : g_hex
    assign hex_line[gi*8 +: 8] = (data_pad[gi*4 +: 4] < 4'd10)
                               ? {4'h3, data_pad[gi*4 +: 4]}
                               : (8'h37 + {4'h0, data_pad[gi*4 +: 4]});
  end

  always_comb begin
    nib_sel  = IDX_DLAST - idx_reg;
    cur_char = 8'(hex_line >> {nib_sel, 3'b000});
    if (idx_reg == IDX_LAST)                      cur_char = 8'h0D;
    else if (idx_reg == IDX_LF)                   cur_char = 8'h0A;
    else if (HDR != 0 && idx_reg == '0)           cur_char = 8'h30 + 8'(frame_ch_reg);
    else if (HDR != 0 && idx_reg == IDX_W'(1))    cur_char = 8'h3A;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      frame_ch_reg   <= '0;
      frame_data_reg <= '0;
      uart_start_reg <= 1'b0;
      uart_data_reg  <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          uart_start_reg <= 1'b0;
          if (pop) begin
            {frame_ch_reg, frame_data_reg} <= fifo_mem[rd_ptr_reg];
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          uart_data_reg <= cur_char;
          if (done_s_reg) state_reg <= REQ;
        end
        REQ: begin
          // Hold the request until the UART acknowledges by dropping done.
          if (done_s_reg) begin
            uart_start_reg <= 1'b1;
          end else begin
            uart_start_reg <= 1'b0;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          if (done_s_reg) begin
            if (idx_reg == IDX_LAST) begin
              idx_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= LOAD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign uart_start = uart_start_reg;
  assign uart_data  = uart_data_reg;
  assign fifo_full  = (count_reg == CNT_FULL);
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Randomised bench for adc_uart_streamer (DATA_W=10, NUM_CH=4, FIFO_DEPTH=4):
// a UART responder plus a byte-stream reference model of the expected ASCII lines.
module tb_adc_uart_streamer;

  localparam int DATA_W     = 10;
  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 2;
  localparam int NHEX       = 3;
  localparam int FLEN       = 7;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [CH_W-1:0]   sample_ch = '0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              ovr_clr = 1'b0;
  logic              uart_line = 1'b1;
  logic              uart_hold = 1'b0;
  logic              uart_done;
  logic              uart_start;
  logic [7:0]        uart_data;
  logic              fifo_full;
  logic              overrun;
  logic              busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         hi_hold = 0;
  logic       cmp_prev = 1'b0;
  logic [7:0] cmp_held = 8'h00;
  logic       u_rst = 1'b0;
  int         u_cnt = 0;

  assign uart_done = uart_line & ~uart_hold;

  adc_uart_streamer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .ovr_clr(ovr_clr),
    .uart_done(uart_done), .uart_start(uart_start), .uart_data(uart_data),
    .fifo_full(fifo_full), .overrun(overrun), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    if (n < 10) return 8'(8'h30 + n);
    return 8'(8'h41 + n - 10);
  endfunction

  // Reference: one sample becomes "<ch>:<3 hex digits>\n\r".
  task automatic expect_frame(input int ch, input int data);
    exp_q.push_back(8'(8'h30 + ch));
    exp_q.push_back(8'h3A);
    for (int j = NHEX - 1; j >= 0; j--) exp_q.push_back(hexc((data >> (4 * j)) & 15));
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
  endtask

  // Called at a negedge; drives one sample for one cycle.
  task automatic push_sample(input int ch, input int data, input bit acc);
    sample_valid = 1'b1;
    sample_ch    = CH_W'(ch);
    sample_data  = DATA_W'(data);
    if (acc) expect_frame(ch, data);
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (!(exp_q.size() == 0 && !busy && uart_done) && cyc < 3000) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    chk(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
  endtask

  task automatic wait_exp_size(input string name, input int sz);
    int cyc = 0;
    while (exp_q.size() != sz && cyc < 2000) begin
      @(negedge CLOCK_50);
      #2;
      cyc++;
    end
    chk(name, exp_q.size(), sz);
  endtask

  // Character stream checker: each rising uart_start must carry the next expected byte.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        cmp_prev = 1'b0;
      end else begin
        if (uart_start && !cmp_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_char: got 0x%0h, expected no character", uart_data);
          end else begin
            chk("char", uart_data, exp_q.pop_front());
          end
          cmp_held = uart_data;
        end else if (uart_start) begin
          chk("data_hold", uart_data, cmp_held);
        end
        cmp_prev = uart_start;
      end
    end
  end

  // UART responder: acknowledge a request by dropping done, stay busy a while.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (reset_n && uart_start && uart_done) begin
        u_rst = 1'b0;
        for (int i = 0; i < hi_hold; i++) begin
          @(negedge CLOCK_50);
          if (!reset_n) u_rst = 1'b1;
        end
        uart_line = 1'b0;
        u_cnt = 0;
        while (uart_start && u_cnt < 10) begin
          @(negedge CLOCK_50);
          u_cnt++;
          if (!reset_n) u_rst = 1'b1;
        end
        if (!u_rst) chk("start_fall_lat", u_cnt, 3);
        repeat ($urandom_range(12, 4)) @(negedge CLOCK_50);
        uart_line = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] lit1 [FLEN];
    logic [7:0] lit2 [FLEN];
    int c;
    int x_ch;
    int x_data;
    lit1 = '{8'h32, 8'h3A, 8'h32, 8'h41, 8'h35, 8'h0A, 8'h0D};
    lit2 = '{8'h30, 8'h3A, 8'h30, 8'h30, 8'h46, 8'h0A, 8'h0D};

    repeat (3) @(negedge CLOCK_50);
    chk("rst_uart_start", uart_start, 0);
    chk("rst_uart_data", uart_data, 8'h00);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // Hand-computed line for ch=2, data=0x2A5 and start latency from an idle FIFO.
    foreach (lit1[i]) exp_q.push_back(lit1[i]);
    push_sample(2, 'h2A5, 1'b0);
    c = 0;
    while (!uart_start && c < 20) begin
      @(negedge CLOCK_50);
      c++;
    end
    chk("start_latency", c, 3);
    wait_idle("drain_2a5");

    foreach (lit2[i]) exp_q.push_back(lit2[i]);
    push_sample(0, 'h00F, 1'b0);
    wait_idle("drain_00f");
    chk("fifo_full_idle", fifo_full, 0);

    // Slow acknowledge: done stays high for 5 cycles after the request.
    hi_hold = 5;
    push_sample($urandom_range(3, 0), $urandom_range(1023, 0), 1'b1);
    wait_idle("drain_slow_ack");
    hi_hold = 0;

    // Random bursts that can never overflow an initially empty, idle streamer.
    for (int b = 0; b < 12; b++) begin
      int n;
      hi_hold = $urandom_range(2, 0);
      n = $urandom_range(FIFO_DEPTH + 1, 1);
      for (int s = 0; s < n; s++) begin
        push_sample($urandom_range(3, 0), $urandom_range(1023, 0), 1'b1);
        repeat ($urandom_range(3, 0)) @(negedge CLOCK_50);
      end
      wait_idle("drain_burst");
      chk("burst_no_overrun", overrun, 0);
    end
    hi_hold = 0;

    // UART stalled: one sample goes to the frame register, four fill the FIFO, the rest drop.
    uart_hold = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    for (int i = 1; i <= 6; i++) push_sample($urandom_range(3, 0), i, i <= 5);
    chk("hold_fifo_full", fifo_full, 1);
    chk("hold_overrun", overrun, 1);
    chk("hold_busy", busy, 1);
    ovr_clr = 1'b1;
    push_sample(0, 7, 1'b0);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    ovr_clr = 1'b1;
    @(negedge CLOCK_50);
    ovr_clr = 1'b0;
    chk("ovr_clear", overrun, 0);
    uart_hold = 1'b0;

    // While full, keep a sample offered across the single pop cycle: exactly one gets in.
    wait_exp_size("first_frame_sent", 4 * FLEN);
    x_ch   = $urandom_range(3, 0);
    x_data = $urandom_range(1023, 0);
    expect_frame(x_ch, x_data);
    sample_valid = 1'b1;
    sample_ch    = CH_W'(x_ch);
    sample_data  = DATA_W'(x_data);
    repeat (30) @(negedge CLOCK_50);
    sample_valid = 1'b0;
    chk("full_after_pop_push", fifo_full, 1);
    ovr_clr = 1'b1;
    @(negedge CLOCK_50);
    ovr_clr = 1'b0;
    chk("ovr_clear2", overrun, 0);
    wait_idle("drain_hold");
    chk("fifo_empty_after_hold", fifo_full, 0);

    // Reset while the second character of a frame is being requested.
    repeat (20) @(negedge CLOCK_50);
    for (int i = 0; i < 3; i++) push_sample($urandom_range(3, 0), $urandom_range(1023, 0), 1'b1);
    wait_exp_size("second_char_req", 3 * FLEN - 2);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    #1;
    chk("midrst_uart_start", uart_start, 0);
    chk("midrst_uart_data", uart_data, 8'h00);
    chk("midrst_fifo_full", fifo_full, 0);
    chk("midrst_busy", busy, 0);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (40) @(negedge CLOCK_50);
    push_sample($urandom_range(3, 0), $urandom_range(1023, 0), 1'b1);
    wait_idle("drain_after_reset");
    chk("final_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
